// File: rtl/led_pkg.sv
// Shared encodings for the LED pattern generator.
// Mode values match the MODE input pin encoding.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_BIN     = 2'd0,
    MODE_SCAN    = 2'd1,
    MODE_ROT     = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

endpackage

// File: rtl/tick_gen.sv
// Step prescaler: DIV-bit counter, one TICK per wrap.
// CLR wins over EN and masks a coincident TICK.
module tick_gen #(
  parameter int DIV = 22
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic EN,
  input  logic CLR,
  output logic TICK
);

  logic [DIV-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (CLR)     cnt_d = '0;
    else if (EN) cnt_d = cnt_q + DIV'(1);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign TICK = EN & ~CLR & (&cnt_q);

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: binary, scanner, rotate, breathe.
// OUT is registered from next-state, so it lands the cycle after TICK.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int DIV      = 22,
  parameter int PWM_BITS = 8
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [1:0]          MODE,
  input  logic                PAUSE,
  output logic [CHANNELS-1:0] OUT,
  output logic                TICK
);

  localparam logic [CHANNELS-1:0] ONE = CHANNELS'(1);

  mode_e               mode_q, act_q, act_d;
  logic [CHANNELS-1:0] cnt_q, cnt_d;
  logic [CHANNELS-1:0] oh_q, oh_d;
  logic                dir_q, dir_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                bdir_q, bdir_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [CHANNELS-1:0] out_q, out_d;
  logic                chg;
  logic                tick;

  // mode_q samples the pin; act_q is the mode actually running
  assign chg = (mode_q != act_q);

  tick_gen #(.DIV(DIV)) u_tick (
    .CLK   (CLK),
    .RST_N (RST_N),
    .EN    (~PAUSE),
    .CLR   (chg),
    .TICK  (tick)
  );

  always_comb begin
    act_d  = act_q;
    cnt_d  = cnt_q;
    oh_d   = oh_q;
    dir_d  = dir_q;
    duty_d = duty_q;
    bdir_d = bdir_q;
    pwm_d  = pwm_q + PWM_BITS'(1);
    if (chg) begin
      act_d  = mode_q;
      cnt_d  = '0;
      oh_d   = ONE;
      dir_d  = 1'b0;
      duty_d = '0;
      bdir_d = 1'b0;
    end else if (tick) begin
      unique case (act_q)
        MODE_BIN: cnt_d = cnt_q + CHANNELS'(1);
        MODE_SCAN: begin
          if (CHANNELS > 1) begin
            if (!dir_q) begin
              if (oh_q[CHANNELS-1]) begin
                oh_d  = oh_q >> 1;
                dir_d = 1'b1;
              end else begin
                oh_d = oh_q << 1;
              end
            end else begin
              if (oh_q[0]) begin
                oh_d  = oh_q << 1;
                dir_d = 1'b0;
              end else begin
                oh_d = oh_q >> 1;
              end
            end
          end
        end
        MODE_ROT:
          oh_d = (oh_q << 1) | (oh_q >> (CHANNELS-1));
        MODE_BREATHE: begin
          // triangle: each endpoint visited once per sweep
          if (!bdir_q) begin
            if (&duty_q) begin
              duty_d = duty_q - PWM_BITS'(1);
              bdir_d = 1'b1;
            end else begin
              duty_d = duty_q + PWM_BITS'(1);
            end
          end else begin
            if (duty_q == '0) begin
              duty_d = duty_q + PWM_BITS'(1);
              bdir_d = 1'b0;
            end else begin
              duty_d = duty_q - PWM_BITS'(1);
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    out_d = '0;
    unique case (act_d)
      MODE_BIN:     out_d = cnt_d;
      MODE_SCAN:    out_d = oh_d;
      MODE_ROT:     out_d = oh_d;
      MODE_BREATHE: out_d = {CHANNELS{pwm_d < duty_d}};
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mode_q <= MODE_BIN;
      act_q  <= MODE_BIN;
      cnt_q  <= '0;
      oh_q   <= ONE;
      dir_q  <= 1'b0;
      duty_q <= '0;
      bdir_q <= 1'b0;
      pwm_q  <= '0;
      out_q  <= '0;
    end else begin
      mode_q <= mode_e'(MODE);
      act_q  <= act_d;
      cnt_q  <= cnt_d;
      oh_q   <= oh_d;
      dir_q  <= dir_d;
      duty_q <= duty_d;
      bdir_q <= bdir_d;
      pwm_q  <= pwm_d;
      out_q  <= out_d;
    end
  end

  assign OUT  = out_q;
  assign TICK = tick;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen, DIV=2, CHANNELS=4, PWM_BITS=2.
// Samples on the falling edge; drives on the falling edge.
module tb_led_pattern_gen;

  logic       clk;
  logic       rst_n;
  logic [1:0] mode;
  logic       pause;
  logic [3:0] out;
  logic       tick;

  int total = 0;
  int bad   = 0;

  led_pattern_gen #(
    .CHANNELS (4),
    .DIV      (2),
    .PWM_BITS (2)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .MODE  (mode),
    .PAUSE (pause),
    .OUT   (out),
    .TICK  (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 16);
    check("tick_seen", {31'd0, tick}, 32'd1);
  endtask

  task automatic set_mode(input logic [1:0] m);
    mode = m;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int hi;
    int tk;
    logic [3:0] scan_v [7];
    logic [3:0] rot_v  [4];
    int bd [7];
    scan_v = '{4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2};
    rot_v  = '{4'h2, 4'h4, 4'h8, 4'h1};
    bd     = '{0, 1, 2, 3, 2, 1, 0};

    rst_n = 1'b0;
    mode  = 2'd0;
    pause = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out", {28'd0, out}, 32'd0);
    check("rst_tick", {31'd0, tick}, 32'd0);
    rst_n = 1'b1;

    for (int i = 1; i <= 16; i++) begin
      wait_tick(n);
      check("bin_period", n, 3);
      @(negedge clk);
      check("bin_out", {28'd0, out}, i % 16);
    end

    set_mode(2'd1);
    check("scan_start", {28'd0, out}, 32'h1);
    for (int i = 0; i < 7; i++) begin
      wait_tick(n);
      @(negedge clk);
      check("scan_out", {28'd0, out}, {28'd0, scan_v[i]});
    end

    set_mode(2'd2);
    check("rot_start", {28'd0, out}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      wait_tick(n);
      @(negedge clk);
      check("rot_out", {28'd0, out}, {28'd0, rot_v[i]});
    end

    set_mode(2'd3);
    for (int i = 0; i < 7; i++) begin
      hi = 0;
      for (int k = 0; k < 4; k++) begin
        if (k > 0) @(negedge clk);
        if (out == 4'hF) hi++;
        else if (out != 4'h0) hi += 100;
      end
      check("br_tick", {31'd0, tick}, 32'd1);
      check("br_duty", hi, bd[i]);
      @(negedge clk);
    end

    set_mode(2'd0);
    check("bin_restart", {28'd0, out}, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      wait_tick(n);
      @(negedge clk);
      check("pre_pause", {28'd0, out}, i);
    end
    repeat (3) @(negedge clk);
    pause = 1'b1;
    tk = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (tick) tk++;
    end
    check("pause_tick", tk, 0);
    check("pause_out", {28'd0, out}, 32'd5);
    pause = 1'b0;
    #1;
    check("resume_tick", {31'd0, tick}, 32'd1);
    @(negedge clk);
    check("resume_out", {28'd0, out}, 32'd6);

    set_mode(2'd1);
    check("scan2_start", {28'd0, out}, 32'h1);
    wait_tick(n);
    @(negedge clk);
    wait_tick(n);
    @(negedge clk);
    check("scan2_pos", {28'd0, out}, 32'h4);
    rst_n = 1'b0;
    #1;
    check("midrst_out", {28'd0, out}, 32'd0);
    check("midrst_tick", {31'd0, tick}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_rescan", {28'd0, out}, 32'h1);

    repeat (2) @(negedge clk);
    mode = 2'd2;
    @(negedge clk);
    check("clr_vs_tick", {31'd0, tick}, 32'd0);
    @(negedge clk);
    check("clr_load", {28'd0, out}, 32'h1);
    wait_tick(n);
    check("clr_period", n, 3);
    @(negedge clk);
    check("clr_step", {28'd0, out}, 32'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
